// File: rtl/lsu_byte_initiator.sv
// lsu_byte_initiator
//
// Initiator side of the data-memory path. Accepts one load/store from the
// CPU datapath and performs it as 1, 2 or 4 little-endian byte transactions
// on a req/ack memory port. Load data is assembled and sign/zero extended.
// Completion is a single-cycle response pulse.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid       CPU request strobe; accepted when req_valid & req_ready
//   req_ready       high only while idle
//   req_write       1 = store, 0 = load
//   req_size        000 sb, 001 sh, 010 word, 100 ub, 101 uh
//   req_addr        base byte address
//   req_wdata       store data (low bytes used)
//   resp_valid      one-cycle completion pulse
//   resp_rdata      extended load data; 0 for stores and errors
//   resp_err        illegal request or ack timeout, valid with resp_valid
//   mem_req         byte request, held until mem_ack
//   mem_we          byte write enable
//   mem_addr        byte address (base + lane, wrapping)
//   mem_wdata       write byte
//   mem_ack         byte done when sampled high together with mem_req
//   mem_rdata       read byte, valid with mem_ack
module lsu_byte_initiator #(
  parameter int ADDR_WIDTH     = 17,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  // Watchdog counter only needs to count up to TIMEOUT_CYCLES-1.
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                state;
  logic [1:0]            cnt;
  logic [1:0]            last_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [WD_W-1:0]       wd_q;

  logic                  req_legal;
  logic [1:0]            req_last;
  logic [1:0]            cnt_next;
  logic [DATA_WIDTH-1:0] merged;
  logic                  wd_hit;

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                   input logic [2:0] s);
    case (s)
      3'b000:  return {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
      3'b001:  return {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
      3'b100:  return {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
      3'b101:  return {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_legal = 1'b0;
    req_last  = 2'd0;
    case (req_size)
      3'b000, 3'b100: begin req_legal = (req_size == 3'b000) || !req_write; req_last = 2'd0; end
      3'b001, 3'b101: begin req_legal = (req_size == 3'b001) || !req_write; req_last = 2'd1; end
      3'b010:         begin req_legal = 1'b1;                               req_last = 2'd3; end
      default:        begin req_legal = 1'b0;                               req_last = 2'd0; end
    endcase

    cnt_next = cnt + 2'd1;

    // Load data with the byte arriving this cycle already placed in its lane,
    // so the final byte can be extended in the same cycle it is acked.
    merged = data_q;
    merged[{cnt, 3'b000} +: 8] = mem_rdata;

    wd_hit = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data register is cleared on reset even though it is also
      // cleared per request; this keeps every output-visible value defined.
      state      <= S_IDLE;
      cnt        <= 2'd0;
      last_q     <= 2'd0;
      base_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= 3'b000;
      wdata_q    <= '0;
      data_q     <= '0;
      wd_q       <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            base_q    <= req_addr;
            write_q   <= req_write;
            size_q    <= req_size;
            wdata_q   <= req_wdata;
            last_q    <= req_last;
            cnt       <= 2'd0;
            data_q    <= '0;
            wd_q      <= '0;
            if (req_legal) begin
              state     <= S_ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata[7:0];
            end else begin
              // Illegal requests never touch the memory port.
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end

        S_ACCESS: begin
          if (mem_ack) begin
            wd_q <= '0;
            if (!write_q) data_q <= merged;
            if (cnt == last_q) begin
              state      <= S_DONE;
              mem_req    <= 1'b0;
              mem_we     <= 1'b0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= write_q ? '0 : extend(merged, size_q);
            end else begin
              // Next byte goes out back-to-back; mem_req stays high.
              cnt       <= cnt_next;
              mem_addr  <= base_q + ADDR_WIDTH'(cnt_next);
              mem_wdata <= wdata_q[{cnt_next, 3'b000} +: 8];
            end
          end else if (wd_hit) begin
            // Abandon the remaining bytes; those already written stay written.
            state      <= S_DONE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_initiator.sv
// Directed bench for lsu_byte_initiator with a byte-wide memory model whose
// ack can be delayed a fixed number of cycles per byte or held low.
module tb_lsu_byte_initiator;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [2:0]    req_size = 3'b000;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack;
  logic [7:0]    mem_rdata;

  always #5 clk = ~clk;

  lsu_byte_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Memory model: ack after wait_cycles idle cycles per byte.
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] wait_cycles = 8'd0;
  logic       ack_en = 1'b1;
  logic [7:0] wait_cnt;

  assign mem_ack   = ack_en && mem_req && (wait_cnt == wait_cycles);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst)                     wait_cnt <= 8'd0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 8'd1;
    else                         wait_cnt <= 8'd0;
  end

  always @(posedge clk) begin
    if (!rst && mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
  end

  int total = 0;
  int bad   = 0;

  // Per-transaction trace, one entry per cycle after acceptance.
  logic          tr_req[$];
  logic          tr_we[$];
  logic [AW-1:0] tr_addr[$];
  logic [7:0]    tr_wd[$];
  int            lat;
  logic [31:0]   r_data;
  logic          r_err;

  task automatic run(input logic w, input logic [2:0] sz, input logic [AW-1:0] a,
                     input logic [31:0] wd);
    tr_req.delete(); tr_we.delete(); tr_addr.delete(); tr_wd.delete();
    lat = 0; r_data = 'x; r_err = 1'bx;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL ready_wait: req_ready=%b want 1", req_ready);
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      tr_req.push_back(mem_req); tr_we.push_back(mem_we);
      tr_addr.push_back(mem_addr); tr_wd.push_back(mem_wdata);
      if (resp_valid) begin lat = n; r_data = resp_rdata; r_err = resp_err; end
    end
    total++;
    if (lat == 0) begin bad++; $display("FAIL resp_timeout: no resp_valid within 40 cycles"); end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({req_ready, resp_valid, resp_err, mem_req, mem_we} !== 5'b0 ||
        resp_rdata !== 32'h0 || mem_addr !== '0 || mem_wdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b rv=%b err=%b req=%b we=%b rd=%h a=%h wd=%h want all 0",
               req_ready, resp_valid, resp_err, mem_req, mem_we, resp_rdata, mem_addr, mem_wdata);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word_load();
    run(1'b0, 3'b010, 17'h10000, 32'h0);
    total++;
    if (lat !== 5 || r_data !== 32'h12345678 || r_err !== 1'b0) begin
      bad++; $display("FAIL word_load: lat=%0d data=%h err=%b want 5 12345678 0", lat, r_data, r_err);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tr_req[i] !== 1'b1 || tr_we[i] !== 1'b0 || tr_addr[i] !== AW'(17'h10000 + i)) begin
        bad++; $display("FAIL word_load_addr%0d: req=%b we=%b addr=%h want 1 0 %h",
                        i, tr_req[i], tr_we[i], tr_addr[i], 17'h10000 + i);
      end
    end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL word_load_after: rv=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_extension();
    logic [2:0]    sz  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [AW-1:0] ad  [4] = '{17'h10010, 17'h10010, 17'h10020, 17'h10020};
    logic [31:0]   exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    int            el  [4] = '{2, 2, 3, 3};
    for (int i = 0; i < 4; i++) begin
      run(1'b0, sz[i], ad[i], 32'h0);
      total++;
      if (lat !== el[i] || r_data !== exp[i] || r_err !== 1'b0) begin
        bad++; $display("FAIL ext_size%b: lat=%0d data=%h err=%b want %0d %h 0",
                        sz[i], lat, r_data, r_err, el[i], exp[i]);
      end
    end
  endtask

  task automatic test_store_wrap();
    logic [AW-1:0] ea [4] = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    logic [7:0]    eb [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run(1'b1, 3'b010, 17'h1FFFE, 32'hDEADBEEF);
    total++;
    if (lat !== 5 || r_data !== 32'h0 || r_err !== 1'b0) begin
      bad++; $display("FAIL store_wrap: lat=%0d data=%h err=%b want 5 0 0", lat, r_data, r_err);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tr_req[i] !== 1'b1 || tr_we[i] !== 1'b1 || tr_addr[i] !== ea[i] ||
          tr_wd[i] !== eb[i] || mem[ea[i]] !== eb[i]) begin
        bad++; $display("FAIL store_wrap_byte%0d: addr=%h wd=%h mem=%h want %h %h",
                        i, tr_addr[i], tr_wd[i], mem[ea[i]], ea[i], eb[i]);
      end
    end
  endtask

  task automatic test_wait_store();
    wait_cycles = 8'd3;
    run(1'b1, 3'b001, 17'h00100, 32'h1234CAFE);
    wait_cycles = 8'd0;
    total++;
    if (lat !== 9 || r_err !== 1'b0 || r_data !== 32'h0) begin
      bad++; $display("FAIL wait_store: lat=%0d data=%h err=%b want 9 0 0", lat, r_data, r_err);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (tr_req[i] !== 1'b1 || tr_addr[i] !== ((i < 4) ? 17'h00100 : 17'h00101) ||
          tr_wd[i] !== ((i < 4) ? 8'hFE : 8'hCA)) begin
        bad++; $display("FAIL wait_store_cycle%0d: req=%b addr=%h wd=%h", i + 1, tr_req[i], tr_addr[i], tr_wd[i]);
      end
    end
    total++;
    if (mem[17'h00100] !== 8'hFE || mem[17'h00101] !== 8'hCA) begin
      bad++; $display("FAIL wait_store_mem: got %h %h want fe ca", mem[17'h00100], mem[17'h00101]);
    end
  endtask

  task automatic test_illegal();
    logic       w  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] sz [4] = '{3'b011, 3'b100, 3'b101, 3'b111};
    for (int i = 0; i < 4; i++) begin
      run(w[i], sz[i], 17'h10000, 32'h55AA55AA);
      total++;
      if (lat !== 1 || r_err !== 1'b1 || r_data !== 32'h0 || tr_req[0] !== 1'b0) begin
        bad++; $display("FAIL illegal_w%b_s%b: lat=%0d err=%b data=%h req=%b want 1 1 0 0",
                        w[i], sz[i], lat, r_err, r_data, tr_req[0]);
      end
    end
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    run(1'b0, 3'b010, 17'h10000, 32'h0);
    ack_en = 1'b1;
    total++;
    if (lat !== 5 || r_err !== 1'b1 || r_data !== 32'h0) begin
      bad++; $display("FAIL timeout: lat=%0d err=%b data=%h want 5 1 0", lat, r_err, r_data);
    end
    total++;
    if ({tr_req[0], tr_req[1], tr_req[2], tr_req[3], tr_req[4]} !== 5'b11110 ||
        tr_addr[3] !== 17'h10000) begin
      bad++; $display("FAIL timeout_req: trace=%b%b%b%b%b addr=%h want 11110 10000",
                      tr_req[0], tr_req[1], tr_req[2], tr_req[3], tr_req[4], tr_addr[3]);
    end
  endtask

  task automatic test_reset_midop();
    logic saw_resp;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 3'b010; req_addr = 17'h10000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 17'h10001) begin
      bad++; $display("FAIL midop_byte2: req=%b addr=%h want 1 10001", mem_req, mem_addr);
    end
    rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL midop_abort: req=%b rv=%b want 0 0", mem_req, resp_valid);
    end
    @(negedge clk) rst = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    total++;
    if (saw_resp !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL midop_after: saw_resp=%b rdy=%b want 0 1", saw_resp, req_ready);
    end
    run(1'b0, 3'b100, 17'h10010, 32'h0);
    total++;
    if (lat !== 2 || r_data !== 32'h00000080 || r_err !== 1'b0) begin
      bad++; $display("FAIL midop_next: lat=%0d data=%h err=%b want 2 00000080 0", lat, r_data, r_err);
    end
  endtask

  initial begin
    mem[17'h10000] = 8'h78; mem[17'h10001] = 8'h56;
    mem[17'h10002] = 8'h34; mem[17'h10003] = 8'h12;
    mem[17'h10010] = 8'h80;
    mem[17'h10020] = 8'h01; mem[17'h10021] = 8'h80;
    mem[17'h00100] = 8'h00; mem[17'h00101] = 8'h00;
    test_reset();
    test_word_load();
    test_extension();
    test_store_wrap();
    test_wait_store();
    test_illegal();
    test_timeout();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
